fifo_tek: RTL and testbench

//  Single-clock synchronous byte FIFO. Buffers up to DEPTH words written via enable_wrt and

---
 rtl/fifo_tek_pkg.sv | 11 +
 rtl/fifo_tek_mem.sv | 26 ++
 rtl/fifo_tek.sv | 78 +++++++
 tb/tb_fifo_tek.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fifo_tek_pkg.sv
// rtl/fifo_tek_pkg.sv - shared defaults and pointer/count types for the byte FIFO
package fifo_tek_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;
    localparam int AW         = $clog2(DEPTH_DEF);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

endpackage

// File: rtl/fifo_tek_mem.sv
// rtl/fifo_tek_mem.sv - DEPTH x DATA_W register array, sync write, async read
module fifo_tek_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately left uninitialised across reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_tek.sv
// rtl/fifo_tek.sv - single-clock byte FIFO with registered read data and flag pulses
module fifo_tek
    import fifo_tek_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       enable_wrt,
    input  logic                       enable_rd,
    output logic [DATA_W-1:0]          data_out,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int             PW       = $clog2(DEPTH);
    localparam logic [PW-1:0]  PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW:0]    CNT_ONE  = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0]    CNT_FULL = (PW+1)'(DEPTH);

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DATA_W-1:0] rd_word;
    logic              rd_ok;
    logic              wr_ok;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

    // A full FIFO still takes a write when the same edge frees a slot.
    assign rd_ok = enable_rd & ~empty;
    assign wr_ok = enable_wrt & (~full | rd_ok);

    fifo_tek_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (PW)
    ) u_mem (
        .clk    (clk),
        .we     (wr_ok & ~rst),
        .waddr  (wr_ptr),
        .wdata  (data_in),
        .raddr  (rd_ptr),
        .rdata  (rd_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= enable_wrt & full & ~rd_ok;
            underflow <= enable_rd & empty;
            if (rd_ok) begin
                data_out <= rd_word;
                rd_ptr   <= rd_ptr + PTR_ONE;
            end
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (wr_ok && !rd_ok) begin
                count <= count + CNT_ONE;
            end else if (rd_ok && !wr_ok) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_fifo_tek.sv
// tb/tb_fifo_tek.sv - directed and random checks of fifo_tek against a queue model
module tb_fifo_tek;
    import fifo_tek_pkg::*;

    localparam int DW = DATA_W_DEF;
    localparam int DP = DEPTH_DEF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          enable_wrt = 1'b0;
    logic          enable_rd = 1'b0;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    cnt_t          count;
    logic          overflow;
    logic          underflow;

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_dout;
    int            total = 0;
    int            bad = 0;
    int            ovf_seen;
    int            udf_seen;

    fifo_tek #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .enable_wrt (enable_wrt),
        .enable_rd  (enable_rd),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input logic exp_ovf, input logic exp_udf);
        check("data_out", 32'(data_out), 32'(exp_dout));
        check("count", 32'(count), 32'(q.size()));
        check("full", 32'(full), 32'(q.size() == DP));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        check("underflow", 32'(underflow), 32'(exp_udf));
        if (overflow === 1'b1) ovf_seen++;
        if (underflow === 1'b1) udf_seen++;
    endtask

    task automatic step(input logic wr, input logic rd, input logic [DW-1:0] din);
        logic rd_acc, wr_acc, exp_ovf, exp_udf;
        int   n;
        @(negedge clk);
        enable_wrt = wr;
        enable_rd  = rd;
        data_in    = din;
        n       = q.size();
        rd_acc  = rd && (n > 0);
        wr_acc  = wr && ((n < DP) || rd_acc);
        exp_ovf = wr && (n == DP) && !rd_acc;
        exp_udf = rd && (n == 0);
        if (rd_acc) exp_dout = q.pop_front();
        if (wr_acc) q.push_back(din);
        @(posedge clk);
        #1;
        check_all(exp_ovf, exp_udf);
    endtask

    task automatic do_reset(input logic wr, input logic rd, input int edges);
        @(negedge clk);
        rst        = 1'b1;
        enable_wrt = wr;
        enable_rd  = rd;
        data_in    = 8'h5A;
        repeat (edges) @(posedge clk);
        #1;
        q.delete();
        exp_dout = '0;
        check_all(1'b0, 1'b0);
        @(negedge clk);
        rst        = 1'b0;
        enable_wrt = 1'b0;
        enable_rd  = 1'b0;
    endtask

    initial begin
        exp_dout = '0;

        // 1 reset
        do_reset(1'b0, 1'b0, 2);

        // 2 ordering with single-cycle pulses
        step(1, 0, 8'h08); step(0, 0, 8'h00);
        step(1, 0, 8'h09); step(0, 0, 8'h00);
        step(1, 0, 8'h0C); step(0, 0, 8'h00);
        step(1, 0, 8'h0A); step(0, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'h00);
            step(0, 0, 8'h00);
        end
        check("t2_last", 32'(data_out), 32'h0A);
        check("t2_empty", 32'(empty), 32'h1);

        // 3 full and overflow
        for (int i = 0; i < DP; i++) step(1, 0, DW'(i));
        check("t3_full", 32'(full), 32'h1);
        check("t3_count", 32'(count), 32'(DP));
        ovf_seen = 0;
        step(1, 0, 8'hFF);
        step(0, 0, 8'h00);
        check("t3_ovf_once", 32'(ovf_seen), 32'h1);
        for (int i = 0; i < DP; i++) begin
            step(0, 1, 8'h00);
            check("t3_rd", 32'(data_out), 32'(i));
        end

        // 4 underflow
        udf_seen = 0;
        step(0, 1, 8'h00);
        step(0, 0, 8'h00);
        check("t4_udf_once", 32'(udf_seen), 32'h1);
        check("t4_hold", 32'(data_out), 32'(DP - 1));
        check("t4_count", 32'(count), 32'h0);

        // 5 simultaneous read+write while full, with pointer wrap
        for (int i = 0; i < DP; i++) step(1, 0, DW'($urandom));
        step(1, 1, 8'hAA);
        check("t5_count", 32'(count), 32'(DP));
        for (int i = 0; i < DP; i++) step(0, 1, 8'h00);
        check("t5_last", 32'(data_out), 32'hAA);

        // 6 reset mid-run with requests pending
        for (int i = 0; i < 3; i++) step(1, 0, DW'(8'h30 + i));
        do_reset(1'b1, 1'b1, 1);
        check("t6_count", 32'(count), 32'h0);
        step(0, 1, 8'h00);
        check("t6_not_stored", 32'(underflow), 32'h1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), DW'($urandom));
        end
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 99) < 65), DW'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
